fpu_addsub: RTL and testbench

FPU_ADDSUB -- requirements
Module: fpu_addsub

---
 rtl/fpu_addsub.sv | 230 +++++++++++++++++++++++
 tb/tb_fpu_addsub.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub.sv
// Multi-cycle IEEE-754-style floating-point adder/subtractor with round-to-nearest-even.
// One operation at a time: accept in IDLE, walk the FSM, pulse rdy in OUT.
module fpu_addsub #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [EXP_W+MAN_W:0] din1,
  input  logic [EXP_W+MAN_W:0] din2,
  input  logic                 op,
  input  logic                 dval,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 rdy,
  output logic                 busy,
  output logic [3:0]           flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int M    = MAN_W + 4;
  localparam int XW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  localparam logic signed [XW-1:0] EMIN   = XW'(1 - BIAS);
  localparam logic signed [XW-1:0] EMAX   = XW'(BIAS);
  localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);
  localparam logic signed [XW-1:0] ONE_X  = XW'(1);
  localparam logic [XW-1:0]        M_X    = XW'(M);
  localparam logic [EXP_W-1:0]     BIAS_F = EXP_W'(BIAS);
  localparam logic [W-1:0]         QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [3:0] {
    IDLE, UNPACK, SPECIAL, ALIGN, ADD, NORM, ROUND, PACK, OUT
  } state_t;

  state_t                 state;
  logic [W-1:0]           a_reg, b_reg;
  logic                   op_reg;
  logic                   sa, sb, s_big, sub_r, inexact_r;
  logic signed [XW-1:0]   ea, eb, exp_r;
  logic [M-1:0]           ma, mb, m_big, m_sml;
  logic [M:0]             sum_r;
  logic [MAN_W:0]         man_r;

  logic                   a_ones, a_frac, a_ezero, b_ones, b_frac, b_ezero;
  logic                   a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  logic signed [XW-1:0]   ea_u, eb_u;

  assign a_ones  = &a_reg[W-2:MAN_W];
  assign a_ezero = ~|a_reg[W-2:MAN_W];
  assign a_frac  = |a_reg[MAN_W-1:0];
  assign b_ones  = &b_reg[W-2:MAN_W];
  assign b_ezero = ~|b_reg[W-2:MAN_W];
  assign b_frac  = |b_reg[MAN_W-1:0];
  assign a_nan   = a_ones & a_frac;
  assign a_inf   = a_ones & ~a_frac;
  assign a_zero  = a_ezero & ~a_frac;
  assign b_nan   = b_ones & b_frac;
  assign b_inf   = b_ones & ~b_frac;
  assign b_zero  = b_ezero & ~b_frac;

  // Subnormals share the minimum normal exponent; their implicit bit is 0.
  assign ea_u = a_ezero ? EMIN : ($signed({2'b00, a_reg[W-2:MAN_W]}) - BIAS_X);
  assign eb_u = b_ezero ? EMIN : ($signed({2'b00, b_reg[W-2:MAN_W]}) - BIAS_X);

  logic                 a_big, sml_sticky;
  logic signed [XW-1:0] diff;
  logic [XW-1:0]        shamt;
  logic [M-1:0]         sml_src, sml_shift, aligned;

  always_comb begin
    a_big   = (ea > eb) || ((ea == eb) && (ma >= mb));
    diff    = a_big ? (ea - eb) : (eb - ea);
    shamt   = diff;
    sml_src = a_big ? mb : ma;
    if (shamt >= M_X) begin
      sml_shift  = '0;
      sml_sticky = |sml_src;
    end else begin
      sml_shift  = sml_src >> shamt;
      sml_sticky = |(sml_src & ~({M{1'b1}} << shamt));
    end
    aligned = {sml_shift[M-1:1], sml_shift[0] | sml_sticky};
  end

  logic [MAN_W:0]   keep;
  logic             g_bit, r_bit, s_bit, round_up;
  logic [MAN_W+1:0] rounded;
  logic [EXP_W-1:0] exp_field;

  always_comb begin
    keep      = sum_r[M-1:3];
    g_bit     = sum_r[2];
    r_bit     = sum_r[1];
    s_bit     = sum_r[0];
    round_up  = g_bit & (r_bit | s_bit | keep[0]);
    rounded   = {1'b0, keep} + {{(MAN_W+1){1'b0}}, round_up};
    exp_field = exp_r[EXP_W-1:0] + BIAS_F;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= 1'b0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      s_big     <= 1'b0;
      sub_r     <= 1'b0;
      inexact_r <= 1'b0;
      ea        <= '0;
      eb        <= '0;
      exp_r     <= '0;
      ma        <= '0;
      mb        <= '0;
      m_big     <= '0;
      m_sml     <= '0;
      sum_r     <= '0;
      man_r     <= '0;
      result    <= '0;
      flags     <= '0;
      rdy       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dval) begin
            a_reg  <= din1;
            b_reg  <= din2;
            op_reg <= op;
            busy   <= 1'b1;
            state  <= UNPACK;
          end
        end
        UNPACK: begin
          sa    <= a_reg[W-1];
          sb    <= b_reg[W-1] ^ op_reg;
          ea    <= ea_u;
          eb    <= eb_u;
          ma    <= {~a_ezero, a_reg[MAN_W-1:0], 3'b000};
          mb    <= {~b_ezero, b_reg[MAN_W-1:0], 3'b000};
          state <= SPECIAL;
        end
        SPECIAL: begin
          state <= OUT;
          rdy   <= 1'b1;
          if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            result <= QNAN;
            flags  <= 4'b1000;
          end else if (a_inf || b_inf) begin
            result <= {(a_inf ? sa : sb), {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags  <= 4'b0000;
          end else if (a_zero && b_zero) begin
            result <= {sa & sb, {(W-1){1'b0}}};
            flags  <= 4'b0001;
          end else if (a_zero) begin
            result <= {sb, b_reg[W-2:0]};
            flags  <= 4'b0000;
          end else if (b_zero) begin
            result <= a_reg;
            flags  <= 4'b0000;
          end else begin
            rdy   <= 1'b0;
            state <= ALIGN;
          end
        end
        ALIGN: begin
          exp_r <= a_big ? ea : eb;
          m_big <= a_big ? ma : mb;
          s_big <= a_big ? sa : sb;
          m_sml <= aligned;
          sub_r <= sa ^ sb;
          state <= ADD;
        end
        ADD: begin
          sum_r <= sub_r ? ({1'b0, m_big} - {1'b0, m_sml}) : ({1'b0, m_big} + {1'b0, m_sml});
          state <= NORM;
        end
        // A zero sum skips normalisation so cancellation cannot stall the pipeline.
        NORM: begin
          if (sum_r[M]) begin
            sum_r <= {1'b0, sum_r[M:2], sum_r[1] | sum_r[0]};
            exp_r <= exp_r + ONE_X;
            state <= ROUND;
          end else if (!sum_r[M-1] && (exp_r > EMIN) && (sum_r != '0)) begin
            sum_r <= sum_r << 1;
            exp_r <= exp_r - ONE_X;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          inexact_r <= g_bit | r_bit | s_bit;
          if (rounded[MAN_W+1]) begin
            man_r <= rounded[MAN_W+1:1];
            exp_r <= exp_r + ONE_X;
          end else begin
            man_r <= rounded[MAN_W:0];
          end
          state <= PACK;
        end
        PACK: begin
          rdy   <= 1'b1;
          state <= OUT;
          if (man_r == '0) begin
            result <= '0;
            flags  <= 4'b0001;
          end else if (exp_r > EMAX) begin
            result <= {s_big, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags  <= 4'b0110;
          end else if (!man_r[MAN_W]) begin
            result <= {s_big, {EXP_W{1'b0}}, man_r[MAN_W-1:0]};
            flags  <= {2'b00, inexact_r, 1'b0};
          end else begin
            result <= {s_big, exp_field, man_r[MAN_W-1:0]};
            flags  <= {2'b00, inexact_r, 1'b0};
          end
        end
        OUT: begin
          rdy   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub.sv
// Scoreboard testbench for fpu_addsub: single and half-like precision instances.
module tb_fpu_addsub;

  logic        clk, rst_n;
  logic [31:0] din1, din2, result;
  logic        op, dval, rdy, busy;
  logic [3:0]  flags;
  logic [15:0] h_din1, h_din2, h_result;
  logic        h_op, h_dval, h_rdy, h_busy;
  logic [3:0]  h_flags;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        o;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_qh[$];
  int   passed = 0;
  int   total  = 0;

  fpu_addsub dut (
    .clk(clk), .rst_n(rst_n), .din1(din1), .din2(din2), .op(op), .dval(dval),
    .result(result), .rdy(rdy), .busy(busy), .flags(flags)
  );

  fpu_addsub #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .din1(h_din1), .din2(h_din2), .op(h_op), .dval(h_dval),
    .result(h_result), .rdy(h_rdy), .busy(h_busy), .flags(h_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input vec_t v);
    @(negedge clk);
    din1 = v.a;
    din2 = v.b;
    op   = v.o;
    dval = 1'b1;
    exp_q.push_back('{res: v.res, flg: v.flg});
  endtask

  // n counts the request cycle as 1; returns at the negedge where rdy is seen
  task automatic wait_rdy(output int n, output bit ok);
    n  = 1;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      dval = 1'b0;
      n++;
      ok = (rdy === 1'b1);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (result !== 32'h0) $display("[TB] FAIL reset_result got %h expected 0", result); else passed++;
    total++; if (flags !== 4'h0) $display("[TB] FAIL reset_flags got %b expected 0000", flags); else passed++;
    total++; if (rdy !== 1'b0) $display("[TB] FAIL reset_rdy got %b expected 0", rdy); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b expected 0", busy); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    vec_t vecs[$];
    exp_t e;
    int   n;
    bit   ok;
    vecs.push_back('{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000});
    vecs.push_back('{32'h40000000, 32'h40400000, 1'b1, 32'hBF800000, 4'b0000});
    vecs.push_back('{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0010});
    vecs.push_back('{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0010});
    vecs.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0010});
    vecs.push_back('{32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, 4'b0010});
    vecs.push_back('{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'b0000});
    vecs.push_back('{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000});
    vecs.push_back('{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'b0000});
    foreach (vecs[i]) begin
      send(vecs[i]);
      wait_rdy(n, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || n > 35) $display("[TB] FAIL basic[%0d] latency got %0d cycles (rdy=%0b) required <= 35", i, n, ok);
      else passed++;
      total++; if (result !== e.res) $display("[TB] FAIL basic[%0d] result got %h expected %h", i, result, e.res); else passed++;
      total++; if (flags !== e.flg) $display("[TB] FAIL basic[%0d] flags got %b expected %b", i, flags, e.flg); else passed++;
    end
  endtask

  task automatic test_special();
    vec_t vecs[$];
    exp_t e;
    int   n;
    bit   ok;
    vecs.push_back('{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000});
    vecs.push_back('{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000});
    vecs.push_back('{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000});
    vecs.push_back('{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000});
    vecs.push_back('{32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4'b0000});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0001});
    vecs.push_back('{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0001});
    vecs.push_back('{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0001});
    vecs.push_back('{32'h00000000, 32'h40A00000, 1'b0, 32'h40A00000, 4'b0000});
    vecs.push_back('{32'h40A00000, 32'h00000000, 1'b1, 32'h40A00000, 4'b0000});
    foreach (vecs[i]) begin
      send(vecs[i]);
      wait_rdy(n, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || n != 4) $display("[TB] FAIL special[%0d] latency got %0d cycles (rdy=%0b) required 4", i, n, ok);
      else passed++;
      total++; if (result !== e.res) $display("[TB] FAIL special[%0d] result got %h expected %h", i, result, e.res); else passed++;
      total++; if (flags !== e.flg) $display("[TB] FAIL special[%0d] flags got %b expected %b", i, flags, e.flg); else passed++;
    end
  endtask

  task automatic test_boundary();
    vec_t vecs[$];
    exp_t e;
    int   n;
    bit   ok;
    vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0110});
    vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0001});
    vecs.push_back('{32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 4'b0001});
    vecs.push_back('{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000});
    vecs.push_back('{32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 4'b0000});
    vecs.push_back('{32'h007FFFFF, 32'h00000001, 1'b0, 32'h00800000, 4'b0000});
    foreach (vecs[i]) begin
      send(vecs[i]);
      wait_rdy(n, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || n > 35) $display("[TB] FAIL boundary[%0d] latency got %0d cycles (rdy=%0b) required <= 35", i, n, ok);
      else passed++;
      total++; if (result !== e.res) $display("[TB] FAIL boundary[%0d] result got %h expected %h", i, result, e.res); else passed++;
      total++; if (flags !== e.flg) $display("[TB] FAIL boundary[%0d] flags got %b expected %b", i, flags, e.flg); else passed++;
    end
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    int   n = 1;
    int   extra = 0;
    bit   ok = 1'b0;
    bit   busy_seen = 1'b1;
    send('{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000});
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      n++;
      if (busy !== 1'b1) busy_seen = 1'b0;
      ok = (rdy === 1'b1);
      din1 = 32'h7F800000;
      din2 = 32'h7FC00000;
      op   = 1'b1;
      dval = !ok;
    end
    dval = 1'b0;
    e = exp_q.pop_front();
    total++; if (!ok) $display("[TB] FAIL busy_ignore rdy timeout after %0d cycles", n); else passed++;
    total++; if (!busy_seen) $display("[TB] FAIL busy_ignore busy dropped before rdy, expected 1 throughout"); else passed++;
    total++; if (result !== e.res) $display("[TB] FAIL busy_ignore result got %h expected %h", result, e.res); else passed++;
    total++; if (flags !== e.flg) $display("[TB] FAIL busy_ignore flags got %b expected %b", flags, e.flg); else passed++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy === 1'b1) extra++;
    end
    total++; if (extra != 0) $display("[TB] FAIL busy_ignore extra rdy pulses got %0d expected 0", extra); else passed++;
  endtask

  task automatic test_back_to_back();
    vec_t vecs[$];
    exp_t e;
    int   n;
    bit   ok;
    vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000});
    vecs.push_back('{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000});
    vecs.push_back('{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000});
    foreach (vecs[i]) begin
      send(vecs[i]);
      if (i > 0) begin
        total++; if (busy !== 1'b0) $display("[TB] FAIL b2b[%0d] busy after rdy got %b expected 0", i, busy); else passed++;
        total++; if (rdy !== 1'b0) $display("[TB] FAIL b2b[%0d] rdy width got %b expected 0 one cycle later", i, rdy); else passed++;
      end
      wait_rdy(n, ok);
      e = exp_q.pop_front();
      total++; if (!ok) $display("[TB] FAIL b2b[%0d] rdy timeout after %0d cycles", i, n); else passed++;
      total++; if (result !== e.res) $display("[TB] FAIL b2b[%0d] result got %h expected %h", i, result, e.res); else passed++;
      total++; if (flags !== e.flg) $display("[TB] FAIL b2b[%0d] flags got %b expected %b", i, flags, e.flg); else passed++;
    end
  endtask

  task automatic test_reset_mid_norm();
    exp_t e;
    int   seen = 0;
    int   n;
    bit   ok;
    @(negedge clk);
    din1 = 32'h3F800001;
    din2 = 32'h3F800000;
    op   = 1'b1;
    dval = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dval = 1'b0;
      if (rdy === 1'b1) seen++;
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (result !== 32'h0) $display("[TB] FAIL midreset_result got %h expected 0", result); else passed++;
    total++; if (flags !== 4'h0) $display("[TB] FAIL midreset_flags got %b expected 0000", flags); else passed++;
    total++; if (busy !== 1'b0) $display("[TB] FAIL midreset_busy got %b expected 0", busy); else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy === 1'b1) seen++;
    end
    total++; if (seen != 0) $display("[TB] FAIL midreset_rdy pulses got %0d expected 0", seen); else passed++;
    send('{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000});
    wait_rdy(n, ok);
    e = exp_q.pop_front();
    total++; if (!ok) $display("[TB] FAIL post_reset rdy timeout after %0d cycles", n); else passed++;
    total++; if (result !== e.res) $display("[TB] FAIL post_reset result got %h expected %h", result, e.res); else passed++;
    total++; if (flags !== e.flg) $display("[TB] FAIL post_reset flags got %b expected %b", flags, e.flg); else passed++;
  endtask

  task automatic test_half();
    vec_t vecs[$];
    exp_t e;
    int   n;
    bit   ok;
    vecs.push_back('{32'h3C00, 32'h3C00, 1'b0, 32'h4000, 4'b0000});
    vecs.push_back('{32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 4'b0110});
    vecs.push_back('{32'h3C00, 32'h3C00, 1'b1, 32'h0000, 4'b0001});
    vecs.push_back('{32'h0001, 32'h0001, 1'b0, 32'h0002, 4'b0000});
    foreach (vecs[i]) begin
      @(negedge clk);
      h_din1 = vecs[i].a[15:0];
      h_din2 = vecs[i].b[15:0];
      h_op   = vecs[i].o;
      h_dval = 1'b1;
      exp_qh.push_back('{res: vecs[i].res, flg: vecs[i].flg});
      n  = 1;
      ok = 1'b0;
      for (int k = 0; k < 64 && !ok; k++) begin
        @(negedge clk);
        h_dval = 1'b0;
        n++;
        ok = (h_rdy === 1'b1);
      end
      e = exp_qh.pop_front();
      total++;
      if (!ok || n > 22) $display("[TB] FAIL half[%0d] latency got %0d cycles (rdy=%0b) required <= 22", i, n, ok);
      else passed++;
      total++; if (h_result !== e.res[15:0]) $display("[TB] FAIL half[%0d] result got %h expected %h", i, h_result, e.res[15:0]); else passed++;
      total++; if (h_flags !== e.flg) $display("[TB] FAIL half[%0d] flags got %b expected %b", i, h_flags, e.flg); else passed++;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    din1   = '0;
    din2   = '0;
    op     = 1'b0;
    dval   = 1'b0;
    h_din1 = '0;
    h_din2 = '0;
    h_op   = 1'b0;
    h_dval = 1'b0;
    $display("[TB] starting fpu_addsub bench");
    test_reset();
    test_basic();
    test_special();
    test_boundary();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_norm();
    test_half();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
